// File: rtl/key_expansion_inv_logic.sv
// AES-128 inverse key schedule. Loads the last round key and walks the key
// schedule backwards, presenting round keys NR..0 one per accepted handshake.
// Each backward step takes two cycles: EMIT presents the key and, on accept,
// undoes the three chained XOR words; SUB then uses the registered S-box
// result to recover word 0.

// Registered AES S-box: one byte in, substituted byte out one cycle later.
module aes_sbox_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte n sits at bit offset (255-n)*8, which is {~n, 3'b000}.
    logic [10:0] base;
    assign base = {~din, 3'b000};

    // Register the lookup; active-high synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'h00;
        end else begin
            dout <= SBOX_TABLE[base +: 8];
        end
    end

endmodule

// Top: inverse key expansion with a valid/ready key output.
module key_expansion_inv_logic #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] key_out,
    output logic         key_valid,
    output logic [3:0]   round_out,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    // Handshake: key_out/round_out are offered while key_valid=1 and stay
    // stable until the cycle key_valid & key_ready is seen at a clock edge;
    // only that edge advances the schedule. key_ready is ignored otherwise.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2
    } state_t;

    localparam logic [3:0] NR_4 = 4'(NR);

    state_t      state, state_next;
    logic [31:0] r0, r1, r2, r3;
    logic [31:0] r0_next, r1_next, r2_next, r3_next;
    logic [3:0]  round, round_next;
    logic        done_q, done_next;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;
    logic [31:0] rot_sub;

    // Round constant of the key whose predecessor is being rebuilt.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // The S-box always looks at R3^R2: on the accepting EMIT edge that is the
    // recovered w3, so its SubWord is ready when SUB runs.
    assign sbox_in = r3 ^ r2;

    aes_sbox_reg u_sbox3 (.clk(clk), .rst(~rst), .din(sbox_in[31:24]), .dout(sbox_out[31:24]));
    aes_sbox_reg u_sbox2 (.clk(clk), .rst(~rst), .din(sbox_in[23:16]), .dout(sbox_out[23:16]));
    aes_sbox_reg u_sbox1 (.clk(clk), .rst(~rst), .din(sbox_in[15:8]),  .dout(sbox_out[15:8]));
    aes_sbox_reg u_sbox0 (.clk(clk), .rst(~rst), .din(sbox_in[7:0]),   .dout(sbox_out[7:0]));

    // RotWord applied after SubWord (byte-wise, so the order is equivalent).
    assign rot_sub = {sbox_out[23:16], sbox_out[15:8], sbox_out[7:0], sbox_out[31:24]};

    // State and datapath registers; synchronous active-low reset aborts a run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            r0     <= 32'h0;
            r1     <= 32'h0;
            r2     <= 32'h0;
            r3     <= 32'h0;
            round  <= 4'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            r0     <= r0_next;
            r1     <= r1_next;
            r2     <= r2_next;
            r3     <= r3_next;
            round  <= round_next;
            done_q <= done_next;
        end
    end

    // Next-state and datapath update for one backward schedule step.
    always_comb begin
        state_next = state;
        r0_next    = r0;
        r1_next    = r1;
        r2_next    = r2;
        r3_next    = r3;
        round_next = round;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    r0_next    = key_in[127:96];
                    r1_next    = key_in[95:64];
                    r2_next    = key_in[63:32];
                    r3_next    = key_in[31:0];
                    round_next = NR_4;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (round == 4'd0) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        r3_next    = r3 ^ r2;
                        r2_next    = r2 ^ r1;
                        r1_next    = r1 ^ r0;
                        state_next = SUB;
                    end
                end
            end
            SUB: begin
                r0_next    = r0 ^ rot_sub ^ {rcon(round), 24'h0};
                round_next = round - 4'd1;
                state_next = EMIT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign key_out   = {r0, r1, r2, r3};
    assign key_valid = (state == EMIT);
    assign round_out = round;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_key_expansion_inv_logic.sv
// Bench for the AES-128 inverse key schedule: FIPS-197 A.1 and C.1 keys,
// backpressure, ignored start, start in the done cycle, and mid-run reset.
module tb_key_expansion_inv_logic;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = 128'h0;
  logic         key_ready = 1'b0;
  logic [127:0] key_out;
  logic         key_valid;
  logic [3:0]   round_out;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;

  int checks = 0;
  int failures = 0;

  // Scoreboard entry: {check_key, round, key}.
  logic [132:0] exp_q[$];

  // FIPS-197 A.1 schedule, indexed by round.
  logic [127:0] fips_keys [0:10];

  // FIPS-197 C.1 (key 000102..0f): only first and last round keys tabled.
  localparam logic [127:0] C1_KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_KEY10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  key_expansion_inv_logic #(.NR(10)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key_in(key_in),
    .key_ready(key_ready),
    .key_out(key_out),
    .key_valid(key_valid),
    .round_out(round_out),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- check helpers ----------------
  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_key(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fips();
    for (int r = 10; r >= 0; r--) exp_q.push_back({1'b1, 4'(r), fips_keys[r]});
  endtask

  task automatic push_c1();
    for (int r = 10; r >= 0; r--) begin
      if (r == 10)     exp_q.push_back({1'b1, 4'(r), C1_KEY10});
      else if (r == 0) exp_q.push_back({1'b1, 4'(r), C1_KEY0});
      else             exp_q.push_back({1'b0, 4'(r), 128'h0});
    end
  endtask

  task automatic pulse_start(input logic [127:0] k);
    key_in = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (!(key_valid && int'(round_out) == r) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_val("wait_round_timeout", int'(round_out), r);
  endtask

  // Advance until done is seen; random key_ready if requested.
  task automatic wait_done(input bit rand_ready);
    int n = 0;
    while (!done && n < 400) begin
      if (rand_ready) key_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    key_ready = 1'b1;
    if (n >= 400) check_val("wait_done_timeout", int'(done), 1);
  endtask

  // Full A.1 run with key_ready=1 and cycle-exact timing checks.
  task automatic fips_timed_run(input string tag);
    bit done_early = 1'b0;
    key_ready = 1'b1;
    push_fips();
    pulse_start(fips_keys[10]);
    check_val({tag, "_r10_valid"}, int'(key_valid), 1);
    check_val({tag, "_r10_round"}, int'(round_out), 10);
    check_key({tag, "_r10_key"}, key_out, fips_keys[10]);
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (e == 2) begin
        check_val({tag, "_r9_round_at_t3"}, int'(round_out), 9);
        check_key({tag, "_r9_key_at_t3"}, key_out, fips_keys[9]);
      end
      if (e == 20) begin
        check_val({tag, "_r0_round_at_t21"}, int'(round_out), 0);
        check_val({tag, "_r0_valid_at_t21"}, int'(key_valid), 1);
      end
      if (e < 21 && done) done_early = 1'b1;
    end
    check_val({tag, "_done_early"}, int'(done_early), 0);
    check_val({tag, "_done_at_t22"}, int'(done), 1);
    check_val({tag, "_busy_at_t22"}, int'(busy), 0);
    check_val({tag, "_valid_at_t22"}, int'(key_valid), 0);
    tick();
    check_val({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [132:0] e;
    if (rst && key_valid && key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got round %0d key %h expected no key", round_out, key_out);
      end else begin
        e = exp_q.pop_front();
        check_val("sb_round", int'(round_out), int'(e[131:128]));
        if (e[132]) check_key("sb_key", key_out, e[127:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit leak;
    fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // Reset held two cycles.
    rst = 1'b0;
    tick();
    tick();
    check_key("reset_key_out", key_out, 128'h0);
    check_val("reset_key_valid", int'(key_valid), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_round_out", int'(round_out), 0);
    check_val("reset_state", int'(state_dbg), 0);
    rst = 1'b1;
    tick();

    // FIPS-197 A.1 with exact timing.
    fips_timed_run("a1");

    // Backpressure at round 7.
    key_ready = 1'b1;
    push_fips();
    pulse_start(fips_keys[10]);
    wait_round(7);
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_key("bp_key_frozen", key_out, fips_keys[7]);
      check_val("bp_round_frozen", int'(round_out), 7);
      check_val("bp_valid_held", int'(key_valid), 1);
    end
    key_ready = 1'b1;
    wait_done(1'b0);
    tick();

    // start during EMIT and SUB with a different key is ignored.
    key_ready = 1'b1;
    push_fips();
    pulse_start(fips_keys[10]);
    key_in = C1_KEY10;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check_val("ign_busy", int'(busy), 1);
    wait_done(1'b0);

    // start in the done cycle begins a new run; C.1 with random key_ready.
    check_val("restart_done_seen", int'(done), 1);
    push_c1();
    pulse_start(C1_KEY10);
    check_val("restart_valid", int'(key_valid), 1);
    check_val("restart_round", int'(round_out), 10);
    check_key("restart_key", key_out, C1_KEY10);
    wait_done(1'b1);
    tick();

    // Reset mid-run at round 5: abort, no done pulse.
    key_ready = 1'b1;
    push_fips();
    pulse_start(fips_keys[10]);
    wait_round(5);
    rst = 1'b0;
    tick();
    exp_q.delete();
    check_val("mid_reset_valid", int'(key_valid), 0);
    check_val("mid_reset_busy", int'(busy), 0);
    check_key("mid_reset_key_out", key_out, 128'h0);
    check_val("mid_reset_round", int'(round_out), 0);
    check_val("mid_reset_done", int'(done), 0);
    rst = 1'b1;
    leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy) leak = 1'b1;
    end
    check_val("mid_reset_no_done", int'(leak), 0);

    // Fresh run after the abort reproduces A.1 exactly.
    fips_timed_run("post_reset");

    tick();
    tick();
    check_val("sb_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
